// File: rtl/aes_ctrl_shadow_writer.sv
// aes_ctrl_shadow_writer: issues the stage-then-commit write to a shadowed control register and supervises it.
// Optional readback compare in CHECK when AES_SHADOW_WR_READBACK_EN is defined.
module aes_ctrl_shadow_writer #(
  parameter int            DW          = 32,
  parameter logic [DW-1:0] RESVAL      = '0,
  parameter int            TIMEOUT_CYC = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [DW-1:0] req_data_i,
  output logic          we_o,
  output logic [DW-1:0] wdata_o,
  input  logic          wr_ack_i,
  input  logic          err_update_i,
  input  logic [DW-1:0] rdata_i,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic [DW-1:0] mirror_q_o
);
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  typedef enum logic [2:0] {IDLE, STAGE, GAP, COMMIT, CHECK, RESP} state_t;
  state_t          r_state, w_next;
  logic [DW-1:0]   r_word, r_mirror;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_code, w_code;
  logic            w_accept, w_timeout, w_rb_bad;
  assign w_accept  = req_ready_o && req_valid_i;
  // the wait cycle that brings the count to the limit times out unless it carries the ack
  assign w_timeout = TIMEOUT_CYC != 0 && we_o && !wr_ack_i && r_cnt == LIM;
`ifdef AES_SHADOW_WR_READBACK_EN
  assign w_rb_bad = rdata_i != r_word;
`else
  assign w_rb_bad = &{1'b0, rdata_i};
`endif
  assign wdata_o    = r_word;
  assign err_code_o = r_code;
  assign mirror_q_o = r_mirror;
  always_ff @(posedge clk_i)
    r_state <= rst_i ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_code = r_code;
    case (r_state)
      IDLE:    if (req_valid_i) begin w_next = STAGE; w_code = 2'd0; end
      STAGE:   if (w_timeout) begin w_next = RESP; w_code = 2'd1; end
               else if (wr_ack_i) w_next = GAP;
      GAP:     w_next = COMMIT;
      COMMIT:  if (w_timeout) begin w_next = RESP; w_code = 2'd1; end
               else if (wr_ack_i) begin
                 w_next = err_update_i ? RESP : CHECK;
                 w_code = err_update_i ? 2'd2 : 2'd0;
               end
      CHECK:   begin w_next = RESP; w_code = err_update_i ? 2'd2 : w_rb_bad ? 2'd3 : 2'd0; end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    req_ready_o = r_state == IDLE;
    we_o        = r_state == STAGE || r_state == COMMIT;
    done_o      = r_state == RESP && r_code == 2'd0;
    err_o       = r_state == RESP && r_code != 2'd0;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_word   <= '0;
      r_cnt    <= '0;
      r_code   <= '0;
      r_mirror <= RESVAL;
    end else begin
      if (w_accept) r_word <= req_data_i;
      r_cnt  <= (we_o && !wr_ack_i) ? r_cnt + CW'(1) : '0;
      r_code <= w_code;
      if (done_o) r_mirror <= r_word;
    end
endmodule

// File: tb/tb_aes_ctrl_shadow_writer.sv
// tb_aes_ctrl_shadow_writer: directed vector table plus hand-written reset-in-GAP sequence.
module tb_aes_ctrl_shadow_writer;
  logic        clk_i = 0, rst_i = 1, req_valid_i = 0, wr_ack_i = 0, err_update_i = 0;
  logic [31:0] req_data_i = 0, rdata_i = 0;
  logic        req_ready_o, we_o, done_o, err_o;
  logic [31:0] wdata_o, mirror_q_o;
  logic [1:0]  err_code_o;
  int          n_cmp = 0, n_bad = 0;

  aes_ctrl_shadow_writer dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data_i(req_data_i), .we_o(we_o), .wdata_o(wdata_o), .wr_ack_i(wr_ack_i),
    .err_update_i(err_update_i), .rdata_i(rdata_i), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o), .mirror_q_o(mirror_q_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    int          sd, cd;
    logic        uc, uk;
    logic [31:0] rb;
    logic        dn;
    logic [1:0]  code;
    int          lat, sh, ch;
    logic [31:0] mir;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // drives one beat: ack on wait index dly (-1 = never), counts cycles with we_o high
  task automatic beat(input int dly, input logic [31:0] w, input logic upd, output int hi, output logic stable);
    hi = 0;
    stable = 1;
    while (we_o && hi < 40) begin
      if (wdata_o !== w) stable = 0;
      wr_ack_i = (hi == dly);
      err_update_i = upd;
      tick;
      hi++;
    end
    wr_ack_i = 0;
    err_update_i = 0;
  endtask

  task automatic run(input vec_t v, input int k);
    int   t, sh, ch;
    logic s1, s2, seen;
    req_data_i = v.data;
    rdata_i = v.rb;
    req_valid_i = 1;
    tick;
    req_valid_i = 0;
    t = 1;
    beat(v.sd, v.data, 1'b0, sh, s1);
    t += sh;
    ch = 0;
    s2 = 1;
    if (!err_o) begin
      chk($sformatf("v%0d_gap_we", k), 32'(we_o), 32'd0);
      tick;
      t++;
      beat(v.cd, v.data, v.uc, ch, s2);
      t += ch;
    end
    err_update_i = v.uk;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (done_o || err_o) seen = 1;
      else begin
        tick;
        t++;
        err_update_i = 0;
      end
    end
    err_update_i = 0;
    chk($sformatf("v%0d_resp_seen", k), 32'(seen), 32'd1);
    chk($sformatf("v%0d_latency", k), t, v.lat);
    chk($sformatf("v%0d_done", k), 32'(done_o), 32'(v.dn));
    chk($sformatf("v%0d_err", k), 32'(err_o), 32'(!v.dn));
    chk($sformatf("v%0d_code", k), 32'(err_code_o), 32'(v.code));
    chk($sformatf("v%0d_stage_we_cycles", k), sh, v.sh);
    chk($sformatf("v%0d_commit_we_cycles", k), ch, v.ch);
    chk($sformatf("v%0d_wdata_stable", k), 32'(s1 && s2), 32'd1);
    tick;
    chk($sformatf("v%0d_pulse_gone", k), 32'(done_o || err_o), 32'd0);
    chk($sformatf("v%0d_code_held", k), 32'(err_code_o), 32'(v.code));
    chk($sformatf("v%0d_ready", k), 32'(req_ready_o), 32'd1);
    chk($sformatf("v%0d_mirror", k), mirror_q_o, v.mir);
  endtask

  initial begin
    vec_t        vt[8];
    logic [1:0]  c6;
    logic        d6;
    logic [31:0] m6;
    int          sh;
    logic        st;
`ifdef AES_SHADOW_WR_READBACK_EN
    c6 = 2'd3; d6 = 0; m6 = 32'h1234_5678;
`else
    c6 = 2'd0; d6 = 1; m6 = 32'h0000_0001;
`endif
    //        data          sd  cd  uc uk  rb            dn  code  lat sh  ch  mirror
    vt[0] = '{32'hA5A5_0001, 0,  0, 0, 0, 32'hA5A5_0001, 1, 2'd0,  5,  1,  1, 32'hA5A5_0001};
    vt[1] = '{32'h1234_5678, 3,  3, 0, 0, 32'h1234_5678, 1, 2'd0, 11,  4,  4, 32'h1234_5678};
    vt[2] = '{32'hDEAD_BEEF, 0, -1, 0, 0, 32'hDEAD_BEEF, 0, 2'd1, 19,  1, 16, 32'h1234_5678};
    vt[3] = '{32'hCAFE_0002, 0,  0, 0, 1, 32'hCAFE_0002, 0, 2'd2,  5,  1,  1, 32'h1234_5678};
    vt[4] = '{32'h0000_0003, 0,  0, 1, 0, 32'h0000_0003, 0, 2'd2,  4,  1,  1, 32'h1234_5678};
    vt[5] = '{32'h0000_0001, 0,  0, 0, 0, 32'h0000_0000, d6, c6,   5,  1,  1, m6};
    vt[6] = '{32'hFFFF_FFFF, -1, 0, 0, 0, 32'hFFFF_FFFF, 0, 2'd1, 17, 16,  0, m6};
    vt[7] = '{32'h0BAD_F00D, 15, 0, 0, 0, 32'h0BAD_F00D, 1, 2'd0, 20, 16,  1, 32'h0BAD_F00D};

    tick;
    tick;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_pulses", 32'({done_o, err_o}), 32'd0);
    chk("rst_code", 32'(err_code_o), 32'd0);
    chk("rst_mirror", mirror_q_o, 32'd0);
    rst_i = 0;
    tick;
    for (int k = 0; k < 8; k++) run(vt[k], k);

    // reset while in GAP with the request still asserted
    req_data_i = 32'h5555_AAAA;
    req_valid_i = 1;
    tick;
    wr_ack_i = 1;
    tick;
    wr_ack_i = 0;
    chk("rg_in_gap", 32'({we_o, req_ready_o, done_o, err_o}), 32'd0);
    rst_i = 1;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk($sformatf("rg_rst%0d_we_pulses", i), 32'({we_o, done_o, err_o}), 32'd0);
    end
    chk("rg_mirror_reset", mirror_q_o, 32'd0);
    rst_i = 0;
    chk("rg_ready_after", 32'(req_ready_o), 32'd1);
    tick;
    req_valid_i = 0;
    chk("rg_accept_we", 32'(we_o), 32'd1);
    chk("rg_accept_wdata", wdata_o, 32'h5555_AAAA);
    beat(0, 32'h5555_AAAA, 1'b0, sh, st);
    tick;
    beat(0, 32'h5555_AAAA, 1'b0, sh, st);
    tick;
    chk("rg_done", 32'(done_o), 32'd1);
    tick;
    chk("rg_mirror", mirror_q_o, 32'h5555_AAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
